// File: rtl/bsg_manycore_eva_xlate_arbiter.sv
// rtl/bsg_manycore_eva_xlate_arbiter.sv - round-robin arbiter sharing one EVA-to-NPA translator
// Owns translator config registers, a registered response stage and an invalid-address counter.
module bsg_manycore_eva_xlate_arbiter #(
  parameter int num_req_p      = 2,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 28,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int cnt_width_p    = 16,
  localparam int id_width_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*data_width_p-1:0] req_eva_i,
  output logic [num_req_p-1:0]             req_yumi_o,
  output logic [data_width_p-1:0]          xlate_eva_o,
  output logic [x_cord_width_p-1:0]        xlate_tgo_x_o,
  output logic [y_cord_width_p-1:0]        xlate_tgo_y_o,
  output logic                             xlate_dram_enable_o,
  input  logic [x_cord_width_p-1:0]        xlate_x_i,
  input  logic [y_cord_width_p-1:0]        xlate_y_i,
  input  logic [addr_width_p-1:0]          xlate_epa_i,
  input  logic                             xlate_invalid_i,
  input  logic                             cfg_w_i,
  input  logic [x_cord_width_p-1:0]        cfg_tgo_x_i,
  input  logic [y_cord_width_p-1:0]        cfg_tgo_y_i,
  input  logic                             cfg_dram_enable_i,
  input  logic                             cfg_clr_cnt_i,
  output logic                             resp_v_o,
  input  logic                             resp_ready_i,
  output logic [id_width_lp-1:0]           resp_id_o,
  output logic [x_cord_width_p-1:0]        resp_x_o,
  output logic [y_cord_width_p-1:0]        resp_y_o,
  output logic [addr_width_p-1:0]          resp_epa_o,
  output logic                             resp_invalid_o,
  output logic [cnt_width_p-1:0]           invalid_cnt_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                 state_q, state_n;
  logic [id_width_lp-1:0] last_q;
  logic [id_width_lp-1:0] win_id;
  logic                   can_accept;
  logic                   grant;
  int                     idx;

  // Search starts one past the last winner; the pointer resets to the top
  // index so requester 0 is checked first after reset.
  always_comb begin
    win_id = '0;
    idx    = 0;
    for (int i = num_req_p; i >= 1; i--) begin
      idx = (int'(last_q) + i) % num_req_p;
      if (req_v_i[idx]) win_id = id_width_lp'(idx);
    end
  end

  assign can_accept = (state_q == EMPTY) | resp_ready_i;
  assign grant      = reset_n_i & can_accept & (|req_v_i);

  always_comb begin
    req_yumi_o = '0;
    if (grant) req_yumi_o[win_id] = 1'b1;
  end

  assign xlate_eva_o = grant ? req_eva_i[win_id*data_width_p +: data_width_p] : '0;

  always_comb begin
    state_n = state_q;
    if (grant)                                 state_n = FULL;
    else if (state_q == FULL && resp_ready_i)  state_n = EMPTY;
  end

  assign resp_v_o = (state_q == FULL);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= EMPTY;
      last_q         <= id_width_lp'(num_req_p - 1);
      resp_id_o      <= '0;
      resp_x_o       <= '0;
      resp_y_o       <= '0;
      resp_epa_o     <= '0;
      resp_invalid_o <= 1'b0;
    end else begin
      state_q <= state_n;
      if (grant) begin
        last_q         <= win_id;
        resp_id_o      <= win_id;
        resp_x_o       <= xlate_x_i;
        resp_y_o       <= xlate_y_i;
        resp_epa_o     <= xlate_epa_i;
        resp_invalid_o <= xlate_invalid_i;
      end
    end
  end

  // Config lands at the edge, so a same-cycle grant still sees the old values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      xlate_tgo_x_o       <= '0;
      xlate_tgo_y_o       <= '0;
      xlate_dram_enable_o <= 1'b1;
    end else if (cfg_w_i) begin
      xlate_tgo_x_o       <= cfg_tgo_x_i;
      xlate_tgo_y_o       <= cfg_tgo_y_i;
      xlate_dram_enable_o <= cfg_dram_enable_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      invalid_cnt_o <= '0;
    end else if (cfg_clr_cnt_i) begin
      invalid_cnt_o <= '0;
    end else if (grant && xlate_invalid_i && (invalid_cnt_o != '1)) begin
      invalid_cnt_o <= invalid_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_eva_xlate_arbiter.sv
// tb/tb_bsg_manycore_eva_xlate_arbiter.sv - scoreboard bench for the EVA translate arbiter
// Stimulus pushes expected responses; a negedge monitor pops and compares them.
module tb_bsg_manycore_eva_xlate_arbiter;

  localparam int N = 2, DW = 32, AW = 28, XW = 7, YW = 7, CW = 4, IW = 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_v;
  logic [N*DW-1:0] req_eva;
  logic [N-1:0]    yumi;
  logic [DW-1:0]   xlate_eva;
  logic [XW-1:0]   tgo_x, xl_x, cfg_x, resp_x;
  logic [YW-1:0]   tgo_y, xl_y, cfg_y, resp_y;
  logic            dram_en, xl_inv, cfg_w, cfg_dram, cfg_clr;
  logic [AW-1:0]   xl_epa, resp_epa;
  logic            resp_v, resp_ready, resp_inv;
  logic [IW-1:0]   resp_id;
  logic [CW-1:0]   inv_cnt;

  always #5 clk = ~clk;

  bsg_manycore_eva_xlate_arbiter #(
    .num_req_p(N), .data_width_p(DW), .addr_width_p(AW),
    .x_cord_width_p(XW), .y_cord_width_p(YW), .cnt_width_p(CW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v), .req_eva_i(req_eva), .req_yumi_o(yumi),
    .xlate_eva_o(xlate_eva), .xlate_tgo_x_o(tgo_x), .xlate_tgo_y_o(tgo_y),
    .xlate_dram_enable_o(dram_en),
    .xlate_x_i(xl_x), .xlate_y_i(xl_y), .xlate_epa_i(xl_epa), .xlate_invalid_i(xl_inv),
    .cfg_w_i(cfg_w), .cfg_tgo_x_i(cfg_x), .cfg_tgo_y_i(cfg_y),
    .cfg_dram_enable_i(cfg_dram), .cfg_clr_cnt_i(cfg_clr),
    .resp_v_o(resp_v), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
    .resp_x_o(resp_x), .resp_y_o(resp_y), .resp_epa_o(resp_epa),
    .resp_invalid_o(resp_inv), .invalid_cnt_o(inv_cnt)
  );

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [AW-1:0] epa;
    logic          inv;
  } xl_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] eva;
    logic [XW-1:0] tx;
    logic [YW-1:0] ty;
    logic          dram;
  } exp_t;

  // Toy translator: DRAM window when bit 31 set, else tile-group relative.
  function automatic xl_t xf(input logic [DW-1:0] eva, input logic [XW-1:0] tx,
                             input logic [YW-1:0] ty, input logic dram);
    xl_t r;
    r.inv = (eva == '0);
    if (dram && eva[31]) begin
      r.x = eva[28:22]; r.y = '0; r.epa = eva[29:2];
    end else begin
      r.x = tx + eva[14:8]; r.y = ty + eva[21:15]; r.epa = {20'd0, eva[9:2]};
    end
    return r;
  endfunction

  xl_t tr;
  always_comb tr = xf(xlate_eva, tgo_x, tgo_y, dram_en);
  assign xl_x = tr.x;
  assign xl_y = tr.y;
  assign xl_epa = tr.epa;
  assign xl_inv = tr.inv;

  int   tests = 0, fails = 0;
  exp_t q[$];
  logic [XW-1:0] sh_x;
  logic [YW-1:0] sh_y;
  logic          sh_dram;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic                       stall_prev = 1'b0;
  logic [IW+XW+YW+AW:0]       prev_f, cur_f;

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      cur_f = {resp_id, resp_x, resp_y, resp_epa, resp_inv};
      if (stall_prev && resp_v) chk("stall_hold", 64'(cur_f), 64'(prev_f));
      if (resp_v && resp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          xl_t  x;
          e = q.pop_front();
          x = xf(e.eva, e.tx, e.ty, e.dram);
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_x", 64'(resp_x), 64'(x.x));
          chk("resp_y", 64'(resp_y), 64'(x.y));
          chk("resp_epa", 64'(resp_epa), 64'(x.epa));
          chk("resp_invalid", 64'(resp_inv), 64'(x.inv));
        end
      end
      stall_prev = resp_v && !resp_ready;
      prev_f = cur_f;
    end
  end

  task automatic drive(input logic [1:0] v, input logic [31:0] e0, input logic [31:0] e1,
                       input logic rdy, input logic [1:0] ey);
    exp_t e;
    req_v = v; req_eva = {e1, e0}; resp_ready = rdy;
    @(negedge clk);
    chk("yumi", 64'(yumi), 64'(ey));
    chk("tgo_x", 64'(tgo_x), 64'(sh_x));
    chk("tgo_y", 64'(tgo_y), 64'(sh_y));
    chk("dram_en", 64'(dram_en), 64'(sh_dram));
    if (ey == 2'b00) begin
      chk("eva_idle", 64'(xlate_eva), 64'd0);
    end else begin
      e.id = ey[1]; e.eva = ey[1] ? e1 : e0;
      e.tx = sh_x; e.ty = sh_y; e.dram = sh_dram;
      q.push_back(e);
    end
    @(posedge clk);
    if (cfg_w) begin sh_x = cfg_x; sh_y = cfg_y; sh_dram = cfg_dram; end
    #1;
    cfg_w = 1'b0; cfg_clr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_v = 2'b11; req_eva = '0; resp_ready = 1'b1;
    cfg_w = 1'b0; cfg_x = '0; cfg_y = '0; cfg_dram = 1'b0; cfg_clr = 1'b0;
    sh_x = '0; sh_y = '0; sh_dram = 1'b1;
    #12;
    chk("rst_resp_v", 64'(resp_v), 64'd0);
    chk("rst_yumi", 64'(yumi), 64'd0);
    chk("rst_cnt", 64'(inv_cnt), 64'd0);
    chk("rst_dram", 64'(dram_en), 64'd1);
    chk("rst_tgo", 64'({tgo_x, tgo_y}), 64'd0);
    @(posedge clk); #1; reset_n = 1'b1;

    drive(2'b01, 32'h8000_0040, 32'h0, 1'b1, 2'b01);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
    chk("cnt_zero", 64'(inv_cnt), 64'd0);

    drive(2'b10, 32'h0, 32'h0, 1'b1, 2'b10);
    chk("cnt_one", 64'(inv_cnt), 64'd1);

    drive(2'b11, 32'h0000_1234, 32'h0000_5678, 1'b1, 2'b01);
    drive(2'b11, 32'h0000_1234, 32'h0000_5678, 1'b1, 2'b10);
    drive(2'b11, 32'h0000_1234, 32'h0000_5678, 1'b1, 2'b01);
    drive(2'b11, 32'h0000_1234, 32'h0000_5678, 1'b1, 2'b10);

    for (int i = 0; i < 3; i++) drive(2'b11, 32'h0000_1234, 32'h0000_5678, 1'b0, 2'b00);
    drive(2'b11, 32'h0000_1234, 32'h0000_5678, 1'b1, 2'b01);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
    chk("drained", 64'(resp_v), 64'd0);

    for (int i = 0; i < 13; i++) drive(2'b10, 32'h0, 32'h0, 1'b1, 2'b10);
    chk("cnt_14", 64'(inv_cnt), 64'd14);
    drive(2'b10, 32'h0, 32'h0, 1'b1, 2'b10);
    chk("cnt_15", 64'(inv_cnt), 64'd15);
    drive(2'b10, 32'h0, 32'h0, 1'b1, 2'b10);
    chk("cnt_sat", 64'(inv_cnt), 64'd15);

    cfg_clr = 1'b1;
    drive(2'b10, 32'h0, 32'h0, 1'b1, 2'b10);
    chk("cnt_clr_prio", 64'(inv_cnt), 64'd0);

    cfg_w = 1'b1; cfg_x = 7'd3; cfg_y = 7'd2; cfg_dram = 1'b0;
    drive(2'b01, 32'h0000_0408, 32'h0, 1'b1, 2'b01);
    chk("cfg_new", 64'({tgo_x, tgo_y, dram_en}), 64'({7'd3, 7'd2, 1'b0}));
    drive(2'b01, 32'h8000_0408, 32'h0, 1'b1, 2'b01);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);

    drive(2'b11, 32'h0000_00A0, 32'h0000_00B0, 1'b0, 2'b10);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_v", 64'(resp_v), 64'd0);
    chk("async_rst_yumi", 64'(yumi), 64'd0);
    q.delete();
    sh_x = '0; sh_y = '0; sh_dram = 1'b1;
    @(posedge clk); #1; reset_n = 1'b1;
    drive(2'b11, 32'h0000_0C00, 32'h0000_0D00, 1'b1, 2'b01);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
